// File: rtl/conway_frame_reader_if.sv
// ----------------------------------------------------------------------------
// conway_frame_reader_if
//   Byte-stream handshake carrying frames out of conway_frame_reader.
//   A byte transfers on a rising clock edge where tvalid and tready are both
//   high.
//
//   Signals:
//     tdata  [7:0]  stream byte (source -> sink)
//     tvalid        byte valid   (source -> sink)
//     tready        sink accepts (sink -> source)
//
//   Modports:
//     master  : the frame source (drives tdata/tvalid, samples tready)
//     slave   : the downstream sink (samples tdata/tvalid, drives tready)
// ----------------------------------------------------------------------------
interface conway_frame_reader_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/conway_frame_reader.sv
// ----------------------------------------------------------------------------
// conway_frame_reader
//   Snapshots one generation of the life grid and streams it out as a
//   388-byte frame:
//     SYNC_BYTE, {4'b0, alives[11:8]}, alives[7:0],
//     384 packed cell bytes (byte k bit i = cell 8k+i),
//     XOR of the 384 cell bytes.
//
//   Ports:
//     clk         rising-edge clock
//     rst         asynchronous, active-low reset
//     state       live generation, cell (x,y) at bit y*MAX_X+x, 1 = alive
//     alives      live-cell count accompanying state
//     start       frame request, only honoured while idle
//     busy        high while a frame is in progress
//     frame_done  one-cycle pulse after the last byte transfers
//     m_axis      byte stream output (master side of conway_frame_reader_if)
// ----------------------------------------------------------------------------
module conway_frame_reader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_X     = 64,
    parameter int unsigned MAX_Y     = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MAX_X*MAX_Y-1:0]   state,
    input  logic [11:0]              alives,
    input  logic                     start,
    output logic                     busy,
    output logic                     frame_done,
    conway_frame_reader_if.master    m_axis
);

    localparam int unsigned NCELLS   = MAX_X * MAX_Y;
    localparam int unsigned NBYTES   = NCELLS / 8;
    localparam logic [8:0]  LAST_IDX = 9'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        HDR2,
        DATA,
        CSUM
    } fsm_t;

    fsm_t              st_q, st_d;
    logic [8:0]        idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              done_q, done_d;
    logic [NCELLS-1:0] shadow_q;
    logic [11:0]       alives_q;

    logic              capture;
    logic              tvalid_c;
    logic              xfer;
    logic [7:0]        data_byte;
    logic [7:0]        tdata_c;

    // ------------------------------------------------------------------------
    // State register and snapshot
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= IDLE;
            idx_q    <= '0;
            csum_q   <= '0;
            done_q   <= 1'b0;
            shadow_q <= '0;
            alives_q <= '0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            csum_q <= csum_d;
            done_q <= done_d;
            // Only the snapshot feeds the output path, so the engine may
            // move on to the next generation while this frame drains.
            if (capture) begin
                shadow_q <= state;
                alives_q <= alives;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output datapath
    // ------------------------------------------------------------------------
    assign tvalid_c  = (st_q != IDLE);
    assign xfer      = tvalid_c && m_axis.tready;
    // Byte k holds cells 8k..8k+7 with the lowest cell in bit 0.
    assign data_byte = shadow_q[{idx_q, 3'b000} +: 8];

    // tdata is a pure function of the registered state, index and snapshot,
    // so it cannot change while the sink stalls.
    always_comb begin
        tdata_c = '0;
        unique case (st_q)
            HDR0:    tdata_c = SYNC_BYTE;
            HDR1:    tdata_c = {4'b0000, alives_q[11:8]};
            HDR2:    tdata_c = alives_q[7:0];
            DATA:    tdata_c = data_byte;
            CSUM:    tdata_c = csum_q;
            default: tdata_c = '0;
        endcase
    end

    assign m_axis.tdata  = tdata_c;
    assign m_axis.tvalid = tvalid_c;
    assign busy          = tvalid_c;
    assign frame_done    = done_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        done_d  = 1'b0;
        capture = 1'b0;

        unique case (st_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    csum_d  = '0;
                    st_d    = HDR0;
                end
            end
            HDR0: begin
                if (xfer) st_d = HDR1;
            end
            HDR1: begin
                if (xfer) st_d = HDR2;
            end
            HDR2: begin
                if (xfer) begin
                    idx_d = '0;
                    st_d  = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    // Checksum accumulates as each data byte leaves, so it
                    // is complete exactly when CSUM is entered.
                    csum_d = csum_q ^ data_byte;
                    idx_d  = idx_q + 9'd1;
                    if (idx_q == LAST_IDX) st_d = CSUM;
                end
            end
            CSUM: begin
                if (xfer) begin
                    done_d = 1'b1;
                    st_d   = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conway_frame_reader.sv
// ----------------------------------------------------------------------------
// tb_conway_frame_reader
//   Scoreboard bench for conway_frame_reader. The stimulus process pushes the
//   expected bytes of each accepted frame into a queue; an independent
//   monitor pops on every transfer and checks bytes, stall stability and
//   the frame_done pulse.
// ----------------------------------------------------------------------------
module tb_conway_frame_reader;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [3071:0] state_i;
    logic [11:0]   alives_i;
    logic          start_i;
    logic          busy;
    logic          frame_done;

    conway_frame_reader_if sif ();

    conway_frame_reader #(
        .SYNC_BYTE (8'hA5),
        .MAX_X     (64),
        .MAX_Y     (48)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .state      (state_i),
        .alives     (alives_i),
        .start      (start_i),
        .busy       (busy),
        .frame_done (frame_done),
        .m_axis     (sif)
    );

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   xfer_cnt = 0;
    int   mode     = 0;   // 0: tready high, 1: toggle, 2: random
    bit   pend_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last);
        exp_t e;
        e.b    = b;
        e.last = last;
        q.push_back(e);
    endtask

    // Reference frame built from the cell list: each live cell c sets bit
    // (c mod 8) of data byte (c div 8).
    task automatic push_frame(input logic [3071:0] s, input logic [11:0] a);
        logic [7:0] d [384];
        logic [7:0] x;
        for (int k = 0; k < 384; k++) d[k] = 8'h00;
        for (int c = 0; c < 3072; c++)
            if (s[c]) d[c / 8][c % 8] = 1'b1;
        x = 8'h00;
        for (int k = 0; k < 384; k++) x = x ^ d[k];
        push_byte(8'hA5, 1'b0);
        push_byte({4'h0, a[11:8]}, 1'b0);
        push_byte(a[7:0], 1'b0);
        for (int k = 0; k < 384; k++) push_byte(d[k], 1'b0);
        push_byte(x, 1'b1);
    endtask

    function automatic logic [3071:0] rand_cells();
        logic [3071:0] r;
        for (int i = 0; i < 96; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Called at posedge+#1; start is sampled on the following edge.
    task automatic do_start(input logic [3071:0] s, input logic [11:0] a, input bit push);
        state_i  = s;
        alives_i = a;
        start_i  = 1'b1;
        if (push) push_frame(s, a);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (frame_done !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (frame_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: got no pulse expected one within %0d cycles", limit);
        end
    endtask

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfer_cnt < target && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_byte", 32'(xfer_cnt >= target), 32'd1);
    endtask

    // tready driver
    always @(posedge clk) begin
        #1;
        case (mode)
            0:       sif.tready = 1'b1;
            1:       sif.tready = ~sif.tready;
            default: sif.tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: sampled mid-cycle, the handshake seen here transfers on the
    // next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pend_done = 0;
            xfer_cnt  = 0;
        end else begin
            check("frame_done", 32'(frame_done), 32'(pend_done));
            if (frame_done) begin
                check("busy_at_done", 32'(busy), 32'd0);
                check("tvalid_at_done", 32'(sif.tvalid), 32'd0);
            end
            pend_done = 0;
            if (sif.tvalid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_byte: got tdata %0h expected no tvalid", sif.tdata);
                end else if (sif.tready) begin
                    e = q.pop_front();
                    check("tdata", 32'(sif.tdata), 32'(e.b));
                    xfer_cnt++;
                    if (e.last) begin
                        check("frame_len", 32'(xfer_cnt), 32'd388);
                        pend_done = 1;
                        xfer_cnt  = 0;
                    end
                end else begin
                    check("tdata_hold", 32'(sif.tdata), 32'(q[0].b));
                end
            end
        end
    end

    initial begin
        logic [3071:0] p;
        logic [3071:0] r;
        int n;

        rst_n    = 1'b0;
        start_i  = 1'b0;
        state_i  = '0;
        alives_i = '0;
        sif.tready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(sif.tvalid), 32'd0);
        check("rst_tdata", 32'(sif.tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start", 32'(sif.tvalid), 32'd0);

        // Three-cell pattern, tready high: latency and length checks.
        p = '0;
        p[49] = 1'b1; p[50] = 1'b1; p[51] = 1'b1;
        push_byte(8'hA5, 1'b0); push_byte(8'h00, 1'b0); push_byte(8'h03, 1'b0);
        for (int k = 0; k < 384; k++) push_byte((k == 6) ? 8'h0E : 8'h00, 1'b0);
        push_byte(8'h0E, 1'b1);
        do_start(p, 12'd3, 1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        check("tvalid_after_start", 32'(sif.tvalid), 32'd1);
        n = 1;
        while (frame_done !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_latency", 32'(n), 32'd389);
        @(posedge clk); #1;

        // All cells alive.
        push_byte(8'hA5, 1'b0); push_byte(8'h0C, 1'b0); push_byte(8'h00, 1'b0);
        for (int k = 0; k < 384; k++) push_byte(8'hFF, 1'b0);
        push_byte(8'h00, 1'b1);
        do_start('1, 12'hC00, 1'b0);
        wait_done(2000);
        @(posedge clk); #1;

        // Snapshot isolation with a toggling sink.
        mode = 1;
        push_byte(8'hA5, 1'b0); push_byte(8'h00, 1'b0); push_byte(8'h03, 1'b0);
        for (int k = 0; k < 384; k++) push_byte((k == 6) ? 8'h0E : 8'h00, 1'b0);
        push_byte(8'h0E, 1'b1);
        do_start(p, 12'd3, 1'b0);
        state_i  = '1;
        alives_i = '1;
        wait_done(4000);
        mode = 0;
        @(posedge clk); #1;

        // Start while busy is dropped; start in the frame_done cycle is taken.
        r = rand_cells();
        do_start(r, 12'($urandom), 1'b1);
        wait_xfers(103);
        start_i = 1'b1;
        state_i = rand_cells();
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(2000);
        do_start(rand_cells(), 12'($urandom), 1'b1);
        check("back_to_back_tvalid", 32'(sif.tvalid), 32'd1);
        wait_done(2000);
        @(posedge clk); #1;

        // Random frames with a random sink.
        mode = 2;
        for (int f = 0; f < 3; f++) begin
            do_start(rand_cells(), 12'($urandom), 1'b1);
            wait_done(4000);
            @(posedge clk); #1;
        end

        // Reset mid-frame aborts without frame_done.
        do_start(rand_cells(), 12'($urandom), 1'b1);
        wait_xfers(203);
        rst_n = 1'b0;
        #1;
        check("abort_tvalid", 32'(sif.tvalid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(frame_done), 32'd0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_idle", 32'(sif.tvalid), 32'd0);
        do_start(rand_cells(), 12'($urandom), 1'b1);
        wait_done(4000);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
